// File: rtl/frame_buf_mgr.sv
// Frame bank manager: allocates write/ready/display banks for a 1-, 2- or
// N-buffer DDR frame store and drives the bank address windows and reset strobes.
module frame_buf_mgr #(
  parameter int              H_PIXEL       = 640,
  parameter int              V_PIXEL       = 480,
  parameter int              BYTES_PER_PIX = 2,
  parameter int              NUM_BUF       = 3,
  parameter int              ADDR_W        = 30,
  parameter longint unsigned BASE_ADDR     = 0
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              init_done,
  input  logic [1:0]        mode,
  input  logic              wr_frame_start,
  input  logic              wr_frame_end,
  input  logic              rd_frame_start,
  output logic [ADDR_W-1:0] wr_b_addr,
  output logic [ADDR_W-1:0] wr_e_addr,
  output logic [ADDR_W-1:0] rd_b_addr,
  output logic [ADDR_W-1:0] rd_e_addr,
  output logic              wr_rst,
  output logic              rd_rst,
  output logic [1:0]        wr_idx,
  output logic [1:0]        rd_idx,
  output logic              rdy_valid,
  output logic              rd_repeat,
  output logic [15:0]       drop_cnt
);

  localparam longint unsigned FRAME_BYTES = longint'(H_PIXEL) * longint'(V_PIXEL)
                                            * longint'(BYTES_PER_PIX);
  localparam logic [ADDR_W-1:0] FB_A   = ADDR_W'(FRAME_BYTES);
  localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_ADDR);

  function automatic logic [ADDR_W-1:0] bank_begin(input logic [1:0] idx);
    return BASE_A + ADDR_W'(idx) * FB_A;
  endfunction

  function automatic logic [15:0] sat_add(input logic [15:0] cnt, input logic [1:0] inc);
    logic [16:0] sum;
    sum = {1'b0, cnt} + 17'(inc);
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  logic [1:0]        r_mode;
  logic [1:0]        r_wr_idx, r_rd_idx, r_rdy_idx;
  logic              r_rdy_valid, r_wr_active, r_rd_repeat;
  logic [15:0]       r_drop_cnt;
  logic              r_wr_rst, r_rd_rst;
  logic [ADDR_W-1:0] r_wr_b_addr, r_wr_e_addr, r_rd_b_addr, r_rd_e_addr;

  logic [1:0]  w_wr_idx, w_rd_idx, w_rdy_idx;
  logic        w_rdy_valid, w_wr_active, w_rd_repeat;
  logic        w_wr_rst, w_rd_rst;
  logic [1:0]  w_inc;
  logic [15:0] w_drop_cnt;
  logic [2:0]  w_act;
  logic        w_found;
  logic        w_mode_chg;

  // Events are applied in order end -> read -> start so each sees the previous one's effect.
  always_comb begin
    w_wr_idx    = r_wr_idx;
    w_rd_idx    = r_rd_idx;
    w_rdy_idx   = r_rdy_idx;
    w_rdy_valid = r_rdy_valid;
    w_wr_active = r_wr_active;
    w_rd_repeat = r_rd_repeat;
    w_wr_rst    = 1'b0;
    w_rd_rst    = 1'b0;
    w_inc       = 2'd0;
    w_found     = 1'b0;
    w_mode_chg  = (mode != r_mode);
    case (mode)
      2'd0:    w_act = 3'd1;
      2'd1:    w_act = 3'd2;
      default: w_act = 3'(NUM_BUF);
    endcase

    if (wr_frame_end && w_wr_active) begin
      if (w_rdy_valid) w_inc = w_inc + 2'd1;
      w_rdy_idx   = r_wr_idx;
      w_rdy_valid = 1'b1;
      w_wr_active = 1'b0;
    end

    if (rd_frame_start) begin
      w_rd_rst = 1'b1;
      if (w_rdy_valid) begin
        w_rd_idx    = w_rdy_idx;
        w_rdy_valid = 1'b0;
        w_rd_repeat = 1'b0;
      end else begin
        w_rd_repeat = 1'b1;
      end
    end

    if (wr_frame_start) begin
      if (w_wr_active) w_inc = w_inc + 2'd1;
      if (mode == 2'd0) begin
        w_wr_idx = 2'd0;
      end else begin
        for (int i = 0; i < 4; i++) begin
          if (!w_found && (3'(i) < w_act) && (2'(i) != w_rd_idx) &&
              !(w_rdy_valid && (2'(i) == w_rdy_idx))) begin
            w_wr_idx = 2'(i);
            w_found  = 1'b1;
          end
        end
        // Every bank busy: steal the ready bank, the oldest unread frame is lost.
        if (!w_found) begin
          w_wr_idx    = (w_rd_idx == 2'd0) ? 2'd1 : 2'd0;
          w_rdy_valid = 1'b0;
          w_inc       = w_inc + 2'd1;
        end
      end
      w_wr_active = 1'b1;
      w_wr_rst    = 1'b1;
    end

    w_drop_cnt = sat_add(r_drop_cnt, w_inc);

    if (!init_done || w_mode_chg) begin
      w_wr_idx    = 2'd0;
      w_rd_idx    = 2'd0;
      w_rdy_idx   = 2'd0;
      w_rdy_valid = 1'b0;
      w_wr_active = 1'b0;
      w_rd_repeat = 1'b0;
      w_drop_cnt  = 16'd0;
      w_wr_rst    = init_done && w_mode_chg;
      w_rd_rst    = init_done && w_mode_chg;
    end
  end

  // Mode copy follows the input even in reset so leaving reset never looks like a mode change.
  always_ff @(posedge sys_clk) begin
    r_mode <= mode;
    if (!sys_rst_n) begin
      r_wr_idx    <= 2'd0;
      r_rd_idx    <= 2'd0;
      r_rdy_idx   <= 2'd0;
      r_rdy_valid <= 1'b0;
      r_wr_active <= 1'b0;
      r_rd_repeat <= 1'b0;
      r_drop_cnt  <= 16'd0;
      r_wr_rst    <= 1'b0;
      r_rd_rst    <= 1'b0;
      r_wr_b_addr <= BASE_A;
      r_wr_e_addr <= BASE_A + FB_A;
      r_rd_b_addr <= BASE_A;
      r_rd_e_addr <= BASE_A + FB_A;
    end else begin
      r_wr_idx    <= w_wr_idx;
      r_rd_idx    <= w_rd_idx;
      r_rdy_idx   <= w_rdy_idx;
      r_rdy_valid <= w_rdy_valid;
      r_wr_active <= w_wr_active;
      r_rd_repeat <= w_rd_repeat;
      r_drop_cnt  <= w_drop_cnt;
      r_wr_rst    <= w_wr_rst;
      r_rd_rst    <= w_rd_rst;
      r_wr_b_addr <= bank_begin(w_wr_idx);
      r_wr_e_addr <= bank_begin(w_wr_idx) + FB_A;
      r_rd_b_addr <= bank_begin(w_rd_idx);
      r_rd_e_addr <= bank_begin(w_rd_idx) + FB_A;
    end
  end

  assign wr_b_addr = r_wr_b_addr;
  assign wr_e_addr = r_wr_e_addr;
  assign rd_b_addr = r_rd_b_addr;
  assign rd_e_addr = r_rd_e_addr;
  assign wr_rst    = r_wr_rst;
  assign rd_rst    = r_rd_rst;
  assign wr_idx    = r_wr_idx;
  assign rd_idx    = r_rd_idx;
  assign rdy_valid = r_rdy_valid;
  assign rd_repeat = r_rd_repeat;
  assign drop_cnt  = r_drop_cnt;

endmodule

// File: doc/frame_buf_mgr.md
# frame_buf_mgr

Multi-buffer frame bank manager that sits between the camera capture path and the DDR3 AXI frame-buffer controller. It generalises fixed two-bank ping-pong into a parametrised single, double or triple-buffer scheme. It tracks which bank is being written, which is ready and which is being displayed, and drives the begin/end write and read addresses plus the address-reset strobes. It also reports dropped and repeated frames. All frame events arrive already synchronised to `sys_clk`.

## Interface
- `H_PIXEL`, 640, active pixels per line
- `V_PIXEL`, 480, active lines per frame
- `BYTES_PER_PIX`, 2, bytes per pixel; FRAME_BYTES = H_PIXEL*V_PIXEL*BYTES_PER_PIX
- `NUM_BUF`, 3, banks allocated in DDR (legal 2..4)
- `BASE_ADDR`, 0, DDR byte address of bank 0
- `ADDR_W`, 30, DDR address width
- `sys_clk`  in  1  system clock
- `sys_rst_n`  in  1  synchronous reset, active-low
- `init_done`  in  1  DDR calibrated and camera configured; events are ignored while 0
- `mode`  in  2  0 = single, 1 = ping-pong, 2 = triple, 3 = treated as 2
- `wr_frame_start`  in  1  one-cycle pulse, camera frame begins
- `wr_frame_end`  in  1  one-cycle pulse, last pixel of frame written
- `rd_frame_start`  in  1  one-cycle pulse, display frame begins
- `wr_b_addr`, `wr_e_addr`  out  ADDR_W  write bank begin address and end address (exclusive)
- `rd_b_addr`, `rd_e_addr`  out  ADDR_W  read bank begin address and end address (exclusive)
- `wr_rst`, `rd_rst`  out  1  one-cycle address-reset strobes
- `wr_idx`, `rd_idx`  out  2  current bank indices
- `rdy_valid`  out  1  a completed, unread frame is held
- `rd_repeat`  out  1  the current display frame is a repeat
- `drop_cnt`  out  16  frames discarded, saturating at 0xFFFF

## Operation
- Active bank count ACT: 1 in mode 0, 2 in mode 1, NUM_BUF in mode 2.
- State registers: `wr_idx`, `rd_idx`, `rdy_idx`, `rdy_valid`, `wr_active`.
- `wr_frame_end` with `wr_active=1`:
  - `rdy_idx<=wr_idx`, `rdy_valid<=1`, `wr_active<=0`.
  - If `rdy_valid` was already 1, the older ready frame is superseded and `drop_cnt++`.
- `wr_frame_end` with `wr_active=0`: ignored.
- `rd_frame_start`:
  - If `rdy_valid`: `rd_idx<=rdy_idx`, `rdy_valid<=0`, `rd_repeat<=0`.
  - Otherwise: `rd_idx` is held and `rd_repeat<=1`.
  - `rd_rst` pulses in both cases.
- `wr_frame_start`:
  - If `wr_active=1`, the unfinished frame is discarded and `drop_cnt++`.
  - Select the lowest bank index < ACT that is not equal to `rd_idx` and not equal to `rdy_idx` (the latter only when `rdy_valid`).
  - If no bank qualifies, select the lowest index ≠ `rd_idx`, clear `rdy_valid` and `drop_cnt++` (ready frame overwritten).
  - Mode 0: always bank 0; tearing is accepted and no drop is counted.
  - Then `wr_active<=1` and `wr_rst` pulses.
- Address arithmetic uses ADDR_W bits, unsigned:
  - begin = BASE_ADDR + idx*FRAME_BYTES
  - end = begin + FRAME_BYTES
- Precedence for events in the same cycle:
  - `wr_frame_end` before `rd_frame_start`: the reader takes the frame just completed.
  - `rd_frame_start` before `wr_frame_start`: the writer excludes the new `rd_idx`.
  - All three in one cycle are handled in that order.
- Mode change: any cycle where `mode` differs from its registered copy returns all state to reset values on the next cycle and pulses `wr_rst` and `rd_rst` once.
- With `init_done=0`, state is held at reset values and all pulses are ignored.

## Timing
- Reset values:
  - Indices 0, `rdy_valid` 0, `wr_active` 0, `rd_repeat` 0, `drop_cnt` 0, `wr_rst`/`rd_rst` 0.
  - `wr_b_addr`=`rd_b_addr`=BASE_ADDR.
  - `wr_e_addr`=`rd_e_addr`=BASE_ADDR+FRAME_BYTES.
- Event to index update: 1 cycle (registered).
- Event to address update and strobe: 1 cycle.
  - Addresses are registered from the next index, so `wr_rst`/`rd_rst` assert in the same cycle the new addresses become valid.
  - Strobes are exactly 1 cycle wide.
- Back-to-back pulses on consecutive cycles are each processed; no event is lost.
- Reset asserted mid-frame: all outputs take reset values on the next edge. No strobes are issued during reset.

## Test plan
- Reset, 640×480×2, BASE=0 -> `wr_b_addr`=0, `wr_e_addr`=0x96000, `rd_e_addr`=0x96000, strobes 0.
- Mode 2: `wr_frame_start` then `wr_frame_end`, then `rd_frame_start` -> write bank 1 (addresses 0x96000..0x12C000); after read, `rd_idx`=1, `rdy_valid`=0; one cycle later `rd_rst`=1.
- Mode 1: three writes with no read -> `wr_idx` sequence 1,1,1 and `drop_cnt`=2.
- Mode 2: `rd_frame_start` with nothing ready -> `rd_repeat`=1, `rd_idx` unchanged, `rd_rst` still pulses.
- `wr_frame_end` and `rd_frame_start` in the same cycle (mode 2) -> `rd_idx` equals the just-finished bank; `rd_repeat`=0.
- Change `mode` from 2 to 0 mid-frame, and separately assert `sys_rst_n`=0 for one cycle mid-frame -> reset values, plus a single `wr_rst`/`rd_rst` pulse for the mode change; `drop_cnt` is cleared only by reset and by the mode change.
